// File: rtl/display_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan controller for an HH:MM:SS clock.
// Scans one digit per slot with a leading all-off interval against ghosting,
// shows a frame-coherent snapshot of the time digits, blinks the field being
// set, and optionally suppresses a leading zero on the tens-of-hours digit.
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 50_000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned BLINK_DIV = 12_500_000,
    parameter int unsigned LZ_BLANK  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] minute_h,
    input  logic [3:0] minute_l,
    input  logic [3:0] second_h,
    input  logic [3:0] second_l,
    input  logic       set_mode,
    input  logic       set_hour,
    input  logic       set_minute,
    input  logic       set_second,
    output logic [7:0] seg,
    output logic [5:0] dig_sel,
    output logic       frame_start
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SLOT_W  = 3;

    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(5);
    localparam logic               LZ_EN     = (LZ_BLANK != 0);

    logic [CNT_W-1:0]   cnt;
    logic [SLOT_W-1:0]  slot;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_vis;

    // Snapshot digits packed {hour_h, hour_l, minute_h, minute_l, second_h, second_l}
    logic [23:0] snap_digits;
    logic        snap_mode;
    logic        snap_hour;
    logic        snap_minute;
    logic        snap_second;

    logic        slot_end;
    logic        frame_end;

    logic [7:0]  seg_nxt;
    logic [5:0]  dig_nxt;
    logic        fs_nxt;
    logic [3:0]  cur_digit;
    logic        cur_flag;
    logic        cur_blank;

    // Seven-segment encoding (active-low, dp off); non-BCD values show a dash
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (slot == SLOT_LAST);

    // Slot timer and slot index
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            slot <= '0;
        end else if (slot_end) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Free-running blink phase, starts visible
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_vis <= ~blink_vis;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Capture digits and set flags once per frame so a frame never tears
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_digits <= '0;
            snap_mode   <= 1'b0;
            snap_hour   <= 1'b0;
            snap_minute <= 1'b0;
            snap_second <= 1'b0;
        end else if (frame_end) begin
            snap_digits <= {hour_h, hour_l, minute_h, minute_l, second_h, second_l};
            snap_mode   <= set_mode;
            snap_hour   <= set_hour;
            snap_minute <= set_minute;
            snap_second <= set_second;
        end
    end

    // Next output values from current slot state and snapshot
    always_comb begin
        seg_nxt   = 8'hFF;
        dig_nxt   = 6'h3F;
        fs_nxt    = (cnt == '0) && (slot == '0);
        cur_digit = 4'd0;
        cur_flag  = 1'b0;
        cur_blank = 1'b0;

        case (slot)
            3'd0: begin cur_digit = snap_digits[23:20]; cur_flag = snap_hour;   end
            3'd1: begin cur_digit = snap_digits[19:16]; cur_flag = snap_hour;   end
            3'd2: begin cur_digit = snap_digits[15:12]; cur_flag = snap_minute; end
            3'd3: begin cur_digit = snap_digits[11:8];  cur_flag = snap_minute; end
            3'd4: begin cur_digit = snap_digits[7:4];   cur_flag = snap_second; end
            3'd5: begin cur_digit = snap_digits[3:0];   cur_flag = snap_second; end
            default: begin cur_digit = 4'd0; cur_flag = 1'b0; end
        endcase

        cur_blank = (snap_mode && !blink_vis && cur_flag)
                 || (LZ_EN && (slot == '0) && (cur_digit == 4'd0));

        if (cnt >= BLANK_LIM) begin
            dig_nxt = ~(6'b00_0001 << slot);
            if (!cur_blank) begin
                seg_nxt = seg_encode(cur_digit);
                // Separator dots after the hour and minute pairs
                if ((slot == 3'd1) || (slot == 3'd3)) begin
                    seg_nxt[7] = 1'b0;
                end
            end
        end
    end

    // Output registers, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg         <= 8'hFF;
            dig_sel     <= 6'h3F;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_nxt;
            dig_sel     <= dig_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
